// File: rtl/melody_sequencer.sv
// Eight-note end-of-cook buzzer melody with a single programmable tone divider.
// Step timing comes from a small melody ROM plus beat and gap counters.
module melody_sequencer #(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_250_000,
    parameter int DIV_SHIFT   = 0
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    output logic       tone_out,
    output logic       busy,
    output logic       done,
    output logic [2:0] note_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [27:0] LAST_1B  = 28'(BEAT_CYCLES - 1);
    localparam logic [27:0] LAST_2B  = 28'(2 * BEAT_CYCLES - 1);
    localparam logic [27:0] LAST_3B  = 28'(3 * BEAT_CYCLES - 1);
    localparam logic [27:0] LAST_4B  = 28'(4 * BEAT_CYCLES - 1);
    localparam logic [27:0] GAP_LAST = 28'(GAP_CYCLES - 1);

    state_t      state;
    state_t      next;
    logic [2:0]  step;
    logic [27:0] dur_cnt;
    logic [27:0] gap_cnt;
    logic [18:0] tone_cnt;

    logic [4:0]  entry;
    logic [2:0]  note;
    logic [1:0]  dur;
    logic [27:0] dur_last;
    logic [18:0] div_raw;
    logic [18:0] div_d;
    logic [18:0] div_half;
    logic        play_end;
    logic        gap_end;
    logic        stay_play;

    // Melody ROM: {note, dur}, beats = dur + 1
    always_comb begin
        entry = 5'd0;
        case (step)
            3'd0: entry = {3'd3, 2'd0};
            3'd1: entry = {3'd3, 2'd0};
            3'd2: entry = {3'd4, 2'd0};
            3'd3: entry = {3'd5, 2'd0};
            3'd4: entry = {3'd5, 2'd0};
            3'd5: entry = {3'd4, 2'd0};
            3'd6: entry = {3'd3, 2'd0};
            3'd7: entry = {3'd2, 2'd1};
            default: entry = 5'd0;
        endcase
    end

    assign note = entry[4:2];
    assign dur  = entry[1:0];

    always_comb begin
        div_raw = 19'd0;
        case (note)
            3'd1: div_raw = 19'd382234;
            3'd2: div_raw = 19'd340530;
            3'd3: div_raw = 19'd303030;
            3'd4: div_raw = 19'd286352;
            3'd5: div_raw = 19'd255102;
            3'd6: div_raw = 19'd227272;
            3'd7: div_raw = 19'd202478;
            default: div_raw = 19'd0;
        endcase
    end

    assign div_d    = div_raw >> DIV_SHIFT;
    assign div_half = div_d >> 1;

    always_comb begin
        dur_last = LAST_1B;
        case (dur)
            2'd0: dur_last = LAST_1B;
            2'd1: dur_last = LAST_2B;
            2'd2: dur_last = LAST_3B;
            2'd3: dur_last = LAST_4B;
            default: dur_last = LAST_1B;
        endcase
    end

    assign play_end = (dur_cnt == dur_last);
    assign gap_end  = (gap_cnt == GAP_LAST);

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (start && !stop)
                    next = PLAY;
            end
            PLAY: begin
                if (stop)
                    next = IDLE;
                else if (play_end)
                    next = GAP;
            end
            GAP: begin
                if (stop)
                    next = IDLE;
                else if (gap_end)
                    next = (step == 3'd7) ? IDLE : PLAY;
            end
            default: next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == PLAY) || (state == GAP);
        note_idx = (state == PLAY) ? note : 3'd0;
    end

    // Counters only run while the current state persists, so each note
    // and each gap starts from zero and every tone starts in phase.
    assign stay_play = (state == PLAY) && (next == PLAY);

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            step     <= 3'd0;
            dur_cnt  <= 28'd0;
            gap_cnt  <= 28'd0;
            tone_cnt <= 19'd0;
            tone_out <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (state == IDLE && next == PLAY)
                step <= 3'd0;
            else if (state == GAP && next == PLAY)
                step <= step + 3'd1;

            dur_cnt <= stay_play ? dur_cnt + 28'd1 : 28'd0;

            if (state == GAP && next == GAP)
                gap_cnt <= gap_cnt + 28'd1;
            else
                gap_cnt <= 28'd0;

            if (stay_play)
                tone_cnt <= (tone_cnt >= div_d - 19'd1) ? 19'd0 : tone_cnt + 19'd1;
            else
                tone_cnt <= 19'd0;

            tone_out <= stay_play && (note != 3'd0) && (tone_cnt < div_half);
            done     <= (state == GAP) && gap_end && (step == 3'd7) && !stop;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with shortened beat/gap and shifted divisors.
// Per-cycle outputs are recorded, then compared against hand-computed tables.
module tb_melody_sequencer;

    logic       clock_in;
    logic       reset_n;
    logic       start;
    logic       stop;
    logic       tone_out;
    logic       busy;
    logic       done;
    logic [2:0] note_idx;

    int checks = 0;
    int errors = 0;

    logic       busy_h [0:1023];
    logic       tone_h [0:1023];
    logic       done_h [0:1023];
    logic [2:0] note_h [0:1023];

    typedef struct {
        int         cyc;
        logic       busy;
        logic [2:0] note;
        logic       done;
        logic       tone;
    } vec_t;

    vec_t tbl [0:26];

    melody_sequencer #(
        .BEAT_CYCLES(100),
        .GAP_CYCLES (10),
        .DIV_SHIFT  (12)
    ) dut (
        .clock_in(clock_in),
        .reset_n (reset_n),
        .start   (start),
        .stop    (stop),
        .tone_out(tone_out),
        .busy    (busy),
        .done    (done),
        .note_idx(note_idx)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock_in);
        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        repeat (2) @(negedge clock_in);
        reset_n = 1'b1;
    endtask

    // start is sampled at edge 0; cycle c is the period after edge c-1.
    // Inputs set in cycle c are sampled at edge c.
    task automatic run(input int n, input int s_a, input int s_b, input int stop_at);
        @(negedge clock_in);
        start = 1'b1;
        stop  = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clock_in);
            busy_h[c] = busy;
            tone_h[c] = tone_out;
            done_h[c] = done;
            note_h[c] = note_idx;
            start = (c == s_a) || (c == s_b);
            stop  = (c == stop_at);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic check_full(input string tag);
        int nb;
        int nd;
        int hi;
        int gap_bad;
        int lo;
        foreach (tbl[i]) begin
            chk($sformatf("%s c%0d busy", tag, tbl[i].cyc), int'(busy_h[tbl[i].cyc]), int'(tbl[i].busy));
            chk($sformatf("%s c%0d note", tag, tbl[i].cyc), int'(note_h[tbl[i].cyc]), int'(tbl[i].note));
            chk($sformatf("%s c%0d done", tag, tbl[i].cyc), int'(done_h[tbl[i].cyc]), int'(tbl[i].done));
            chk($sformatf("%s c%0d tone", tag, tbl[i].cyc), int'(tone_h[tbl[i].cyc]), int'(tbl[i].tone));
        end
        nb = 0;
        nd = 0;
        for (int c = 1; c <= 990; c++) begin
            nb += int'(busy_h[c]);
            nd += int'(done_h[c]);
        end
        chk({tag, " busy_cycles"}, nb, 980);
        chk({tag, " done_cycles"}, nd, 1);
        hi = 0;
        for (int c = 2; c <= 74; c++)
            hi += int'(tone_h[c]);
        chk({tag, " mi_high_per_period"}, hi, 36);
        gap_bad = 0;
        for (int k = 0; k < 8; k++) begin
            lo = (k < 7) ? 101 + 110 * k : 971;
            for (int c = lo; c < lo + 10; c++)
                if (tone_h[c] || note_h[c] != 3'd0 || !busy_h[c])
                    gap_bad++;
        end
        chk({tag, " gap_silence"}, gap_bad, 0);
    endtask

    initial begin
        tbl[0]  = '{1,   1'b1, 3'd3, 1'b0, 1'b0};
        tbl[1]  = '{2,   1'b1, 3'd3, 1'b0, 1'b1};
        tbl[2]  = '{37,  1'b1, 3'd3, 1'b0, 1'b1};
        tbl[3]  = '{38,  1'b1, 3'd3, 1'b0, 1'b0};
        tbl[4]  = '{74,  1'b1, 3'd3, 1'b0, 1'b0};
        tbl[5]  = '{75,  1'b1, 3'd3, 1'b0, 1'b1};
        tbl[6]  = '{100, 1'b1, 3'd3, 1'b0, 1'b1};
        tbl[7]  = '{101, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[8]  = '{110, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[9]  = '{111, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[10] = '{112, 1'b1, 3'd3, 1'b0, 1'b1};
        tbl[11] = '{220, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[12] = '{221, 1'b1, 3'd4, 1'b0, 1'b0};
        tbl[13] = '{255, 1'b1, 3'd4, 1'b0, 1'b1};
        tbl[14] = '{256, 1'b1, 3'd4, 1'b0, 1'b0};
        tbl[15] = '{331, 1'b1, 3'd5, 1'b0, 1'b0};
        tbl[16] = '{441, 1'b1, 3'd5, 1'b0, 1'b0};
        tbl[17] = '{551, 1'b1, 3'd4, 1'b0, 1'b0};
        tbl[18] = '{661, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[19] = '{771, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[20] = '{812, 1'b1, 3'd2, 1'b0, 1'b1};
        tbl[21] = '{813, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[22] = '{970, 1'b1, 3'd2, 1'b0, 1'b1};
        tbl[23] = '{971, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[24] = '{980, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[25] = '{981, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[26] = '{982, 1'b0, 3'd0, 1'b0, 1'b0};

        reset_n = 1'b0;
        start   = 1'b1;
        stop    = 1'b0;

        // Reset held with start asserted
        repeat (3) @(negedge clock_in);
        chk("rst tone", int'(tone_out), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst note", int'(note_idx), 0);
        reset_n = 1'b1;
        start   = 1'b0;
        @(negedge clock_in);
        chk("rst idle_after_release", int'(busy), 0);

        run(990, -1, -1, -1);
        check_full("full");

        do_reset();
        run(990, 50, 105, -1);
        check_full("ign");

        // Abort during fa (step 2)
        do_reset();
        run(300, -1, -1, 250);
        begin
            int nd;
            int nb;
            chk("abort c250 note", int'(note_h[250]), 4);
            chk("abort c251 busy", int'(busy_h[251]), 0);
            chk("abort c251 tone", int'(tone_h[251]), 0);
            chk("abort c251 note", int'(note_h[251]), 0);
            nd = 0;
            nb = 0;
            for (int c = 1; c <= 300; c++) begin
                nd += int'(done_h[c]);
                nb += int'(busy_h[c]);
            end
            chk("abort done_cycles", nd, 0);
            chk("abort busy_cycles", nb, 250);
        end

        // start and stop together, then stop held high
        do_reset();
        @(negedge clock_in);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clock_in);
        chk("conflict busy", int'(busy), 0);
        start = 1'b0;
        @(negedge clock_in);
        start = 1'b1;
        @(negedge clock_in);
        chk("stop_held busy1", int'(busy), 0);
        @(negedge clock_in);
        chk("stop_held busy2", int'(busy), 0);
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clock_in);
        chk("stop_held busy3", int'(busy), 0);

        // Restart in the done cycle
        do_reset();
        run(990, 981, -1, -1);
        chk("restart c981 done", int'(done_h[981]), 1);
        chk("restart c981 busy", int'(busy_h[981]), 0);
        chk("restart c982 busy", int'(busy_h[982]), 1);
        chk("restart c982 note", int'(note_h[982]), 3);
        chk("restart c982 tone", int'(tone_h[982]), 0);
        chk("restart c983 tone", int'(tone_h[983]), 1);
        chk("restart c983 done", int'(done_h[983]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
